// File: rtl/fifo_nibble_packer.sv
// Read-side drain for a show-ahead-off nibble FIFO: issues reads, checks parity,
// packs nibble pairs into bytes and presents them on a valid/ready interface.
module fifo_nibble_packer #(
  parameter int LPM_WIDTH  = 4,
  parameter bit LOW_FIRST  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Empty,
  input  logic [LPM_WIDTH-1:0]   Q,
  input  logic                   EDO,
  output logic                   RdReq,
  input  logic                   Flush,
  output logic [2*LPM_WIDTH-1:0] ByteOut,
  output logic                   ByteValid,
  input  logic                   ByteReady,
  output logic                   ByteOdd,
  output logic                   ParErr
);

  logic                   pend_q, pend_d;
  logic                   p_q, p_d;
  logic                   ov_q, ov_d;
  logic                   odd_q, odd_d;
  logic                   perr_q, perr_d;
  logic [LPM_WIDTH-1:0]   a_q, a_d;
  logic [2*LPM_WIDTH-1:0] byte_q, byte_d;

  logic flush_active;
  logic out_free;
  logic rd_req;
  logic par_exp;

  always_comb begin
    flush_active = Flush & p_q & ~pend_q & Empty;
    out_free     = ~ov_q | ByteReady;
    // A read that will complete a pair is only issued when the output
    // register is guaranteed free on arrival, so no skid buffer is needed.
    rd_req       = ~Reset & ~Empty & ~flush_active &
                   (~(p_q ^ pend_q) | (~(p_q & pend_q) & out_free));
    par_exp      = ODD_PARITY ? ~(^Q) : ^Q;

    pend_d = rd_req;
    p_d    = p_q;
    a_d    = a_q;
    byte_d = byte_q;
    odd_d  = odd_q;
    perr_d = perr_q;
    ov_d   = ov_q & ~ByteReady;

    if (pend_q) begin
      if (EDO != par_exp) perr_d = 1'b1;
      if (!p_q) begin
        a_d = Q;
        p_d = 1'b1;
      end else begin
        byte_d = LOW_FIRST ? {Q, a_q} : {a_q, Q};
        ov_d   = 1'b1;
        odd_d  = 1'b0;
        p_d    = 1'b0;
      end
    end else if (flush_active && out_free) begin
      byte_d = LOW_FIRST ? {{LPM_WIDTH{1'b0}}, a_q} : {a_q, {LPM_WIDTH{1'b0}}};
      ov_d   = 1'b1;
      odd_d  = 1'b1;
      p_d    = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend_q <= 1'b0;
      p_q    <= 1'b0;
      ov_q   <= 1'b0;
      odd_q  <= 1'b0;
      perr_q <= 1'b0;
      a_q    <= '0;
      byte_q <= '0;
    end else begin
      pend_q <= pend_d;
      p_q    <= p_d;
      ov_q   <= ov_d;
      odd_q  <= odd_d;
      perr_q <= perr_d;
      a_q    <= a_d;
      byte_q <= byte_d;
    end
  end

  assign RdReq     = rd_req;
  assign ByteOut   = byte_q;
  assign ByteValid = ov_q;
  assign ByteOdd   = odd_q;
  assign ParErr    = perr_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: FIFO model feeding three variants (low-first,
// high-first, odd parity) with a byte scoreboard checked on every transfer.
module tb_fifo_nibble_packer;

  typedef struct packed {
    logic       odd;
    logic [7:0] lo;
    logic [7:0] hi;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Empty = 1'b1;
  logic       EDO = 1'b0;
  logic       Flush = 1'b0;
  logic       ByteReady = 1'b1;
  logic [3:0] Q = 4'h0;

  logic       rd_a, rd_b, rd_c;
  logic [7:0] bo_a, bo_b, bo_c;
  logic       bv_a, bv_b, bv_c;
  logic       odd_a, odd_b, odd_c;
  logic       pe_a, pe_b, pe_c;

  logic [4:0] fifo[$];
  exp_t       exp_q[$];
  exp_t       e_pop;
  logic [4:0] w_pop;
  logic       have_lo = 1'b0;
  logic [3:0] lo_nib = 4'h0;
  int         n_vec = 0;
  int         n_err = 0;

  fifo_nibble_packer #(.LPM_WIDTH(4), .LOW_FIRST(1'b1), .ODD_PARITY(1'b0)) u_a (
    .Clock(Clock), .Reset(Reset), .Empty(Empty), .Q(Q), .EDO(EDO), .RdReq(rd_a),
    .Flush(Flush), .ByteOut(bo_a), .ByteValid(bv_a), .ByteReady(ByteReady),
    .ByteOdd(odd_a), .ParErr(pe_a));

  fifo_nibble_packer #(.LPM_WIDTH(4), .LOW_FIRST(1'b0), .ODD_PARITY(1'b0)) u_b (
    .Clock(Clock), .Reset(Reset), .Empty(Empty), .Q(Q), .EDO(EDO), .RdReq(rd_b),
    .Flush(Flush), .ByteOut(bo_b), .ByteValid(bv_b), .ByteReady(ByteReady),
    .ByteOdd(odd_b), .ParErr(pe_b));

  fifo_nibble_packer #(.LPM_WIDTH(4), .LOW_FIRST(1'b1), .ODD_PARITY(1'b1)) u_c (
    .Clock(Clock), .Reset(Reset), .Empty(Empty), .Q(Q), .EDO(EDO), .RdReq(rd_c),
    .Flush(Flush), .ByteOut(bo_c), .ByteValid(bv_c), .ByteReady(ByteReady),
    .ByteOdd(odd_c), .ParErr(pe_c));

  always #5 Clock = ~Clock;

  // Show-ahead-off FIFO: data appears the cycle after an accepted read.
  always @(posedge Clock) begin
    if (rd_a && !Empty) begin
      w_pop = fifo.pop_front();
      Q     <= w_pop[3:0];
      EDO   <= w_pop[4];
      Empty <= (fifo.size() == 0);
    end
  end

  always begin
    @(negedge Clock);
    #2;
    if (!Reset && bv_a && ByteReady) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte got=%h want=none", bo_a);
      end else begin
        e_pop = exp_q.pop_front();
        if (bo_a !== e_pop.lo || odd_a !== e_pop.odd || bv_b !== 1'b1 ||
            bo_b !== e_pop.hi || odd_b !== e_pop.odd || bv_c !== 1'b1 ||
            bo_c !== e_pop.lo || odd_c !== e_pop.odd) begin
          n_err++;
          $display("FAIL byte got lo=%h hi=%h c=%h odd=%b%b%b want lo=%h hi=%h odd=%b",
                   bo_a, bo_b, bo_c, odd_a, odd_b, odd_c, e_pop.lo, e_pop.hi, e_pop.odd);
        end
      end
    end
  end

  function automatic logic even_par(input logic [3:0] v);
    return ^v;
  endfunction

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic model_nib(input logic [3:0] v);
    if (!have_lo) begin
      lo_nib  = v;
      have_lo = 1'b1;
    end else begin
      exp_q.push_back('{odd: 1'b0, lo: {v, lo_nib}, hi: {lo_nib, v}});
      have_lo = 1'b0;
    end
  endtask

  task automatic push_nib(input logic [3:0] v, input logic e, input bit model);
    fifo.push_back({e, v});
    Empty = 1'b0;
    if (model) model_nib(v);
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec++;
    if (rd_a !== 1'b0 || bv_a !== 1'b0 || odd_a !== 1'b0 || pe_a !== 1'b0 || bo_a !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state got rd=%b bv=%b odd=%b pe=%b bo=%h want 0 0 0 0 00",
               rd_a, bv_a, odd_a, pe_a, bo_a);
    end
  endtask

  task automatic test_basic();
    logic [9:0] rd_hist, rdb_hist, rdc_hist, bv_hist;
    push_nib(4'h1, even_par(4'h1), 1'b1);
    push_nib(4'h2, even_par(4'h2), 1'b1);
    ByteReady = 1'b1;
    tick();
    n_vec++;
    if (rd_a !== 1'b0) begin
      n_err++;
      $display("FAIL rdreq_in_reset got=%b want=0", rd_a);
    end
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      rd_hist[i]  = rd_a;
      rdb_hist[i] = rd_b;
      rdc_hist[i] = rd_c;
      bv_hist[i]  = bv_a;
      tick();
    end
    n_vec++;
    if (rd_hist !== 10'b00_0000_0011 || rdb_hist !== 10'b00_0000_0011 || rdc_hist !== 10'b00_0000_0011) begin
      n_err++;
      $display("FAIL basic_rdreq got=%b/%b/%b want=0000000011", rd_hist, rdb_hist, rdc_hist);
    end
    n_vec++;
    if (bv_hist !== 10'b00_0000_1000) begin
      n_err++;
      $display("FAIL basic_valid_timing got=%b want=0000001000", bv_hist);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_drain pending=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int waited;
    ByteReady = 1'b0;
    push_nib(4'hA, even_par(4'hA), 1'b1);
    push_nib(4'hB, even_par(4'hB), 1'b1);
    push_nib(4'hC, even_par(4'hC), 1'b1);
    push_nib(4'hD, even_par(4'hD), 1'b1);
    waited = 0;
    while (!bv_a && waited < 20) begin
      tick();
      waited++;
    end
    n_vec++;
    if (!bv_a) begin
      n_err++;
      $display("FAIL bp_first_byte timeout got bv=%b want=1", bv_a);
    end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (bo_a !== 8'hBA || bo_b !== 8'hAB || bv_a !== 1'b1 || rd_a !== 1'b0 || fifo.size() != 1) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got bo=%h/%h bv=%b rd=%b left=%0d want BA/AB 1 0 1",
                 k, bo_a, bo_b, bv_a, rd_a, fifo.size());
      end
      tick();
    end
    ByteReady = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (exp_q.size() != 0 || fifo.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain pending=%0d fifo=%0d want=0 0", exp_q.size(), fifo.size());
    end
  endtask

  task automatic test_parity();
    n_vec++;
    if (pe_a !== 1'b0 || pe_c !== 1'b1) begin
      n_err++;
      $display("FAIL parity_initial got even=%b odd=%b want 0 1", pe_a, pe_c);
    end
    push_nib(4'h7, 1'b0, 1'b1);
    push_nib(4'h1, even_par(4'h1), 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (pe_a !== 1'b1 || pe_b !== 1'b1) begin
      n_err++;
      $display("FAIL parity_set got=%b/%b want=1", pe_a, pe_b);
    end
    push_nib(4'h3, even_par(4'h3), 1'b1);
    push_nib(4'hC, even_par(4'hC), 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (pe_a !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL parity_sticky got pe=%b pending=%0d want 1 0", pe_a, exp_q.size());
    end
    Reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if (pe_a !== 1'b0 || pe_c !== 1'b0) begin
      n_err++;
      $display("FAIL parity_reset got even=%b odd=%b want 0 0", pe_a, pe_c);
    end
    Reset = 1'b0;
    push_nib(4'h6, ~even_par(4'h6), 1'b1);
    push_nib(4'h9, ~even_par(4'h9), 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (pe_a !== 1'b1 || pe_c !== 1'b0) begin
      n_err++;
      $display("FAIL parity_odd_mode got even=%b odd=%b want 1 0", pe_a, pe_c);
    end
  endtask

  task automatic test_flush();
    push_nib(4'h5, even_par(4'h5), 1'b1);
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (bv_a !== 1'b0 || rd_a !== 1'b0) begin
      n_err++;
      $display("FAIL flush_lone_held got bv=%b rd=%b want 0 0", bv_a, rd_a);
    end
    Flush = 1'b1;
    exp_q.push_back('{odd: 1'b1, lo: {4'h0, lo_nib}, hi: {lo_nib, 4'h0}});
    have_lo = 1'b0;
    tick();
    Flush = 1'b0;
    n_vec++;
    if (bv_a !== 1'b1 || odd_a !== 1'b1 || bo_a !== 8'h05 || bo_b !== 8'h50) begin
      n_err++;
      $display("FAIL flush_byte got bv=%b odd=%b bo=%h/%h want 1 1 05/50", bv_a, odd_a, bo_a, bo_b);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    Flush = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (bv_a !== 1'b0) begin
        n_err++;
        $display("FAIL flush_idle cyc=%0d got bv=%b want=0", k, bv_a);
      end
    end
    Flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_nib(4'h8, even_par(4'h8), 1'b0);
    push_nib(4'h9, even_par(4'h9), 1'b0);
    #1;
    n_vec++;
    if (rd_a !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_first_rd got=%b want=1", rd_a);
    end
    tick();
    Reset = 1'b1;
    #1;
    n_vec++;
    if (rd_a !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_rd_gated got=%b want=0", rd_a);
    end
    tick();
    tick();
    n_vec++;
    if (bv_a !== 1'b0 || fifo.size() != 1) begin
      n_err++;
      $display("FAIL rmid_state got bv=%b fifo=%0d want 0 1", bv_a, fifo.size());
    end
    Reset = 1'b0;
    have_lo = 1'b0;
    model_nib(4'h9);
    push_nib(4'hA, even_par(4'hA), 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (exp_q.size() != 0 || bv_a !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_recover pending=%0d bv=%b want 0 0", exp_q.size(), bv_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'($urandom_range(0, 15));
      push_nib(v, even_par(v), 1'b1);
    end
    for (int i = 0; i < 60; i++) begin
      ByteReady = 1'($urandom_range(0, 1));
      tick();
    end
    ByteReady = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (exp_q.size() != 0 || fifo.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain pending=%0d fifo=%0d want 0 0", exp_q.size(), fifo.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_parity();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
